// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two request ports, the shared memory and the arbiter.
interface mem_arbiter_if #(
  parameter int REQ_W  = 72,
  parameter int RESP_W = 32
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [REQ_W-1:0]  if_req_data;
  logic              ex_req_valid;
  logic              ex_req_ready;
  logic [REQ_W-1:0]  ex_req_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [REQ_W-1:0]  mem_req_data;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [RESP_W-1:0] mem_resp_data;
  logic              if_resp_valid;
  logic              if_resp_ready;
  logic [RESP_W-1:0] if_resp_data;
  logic              ex_resp_valid;
  logic              ex_resp_ready;
  logic [RESP_W-1:0] ex_resp_data;

  modport master (
    input  if_req_valid, if_req_data, ex_req_valid, ex_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  if_resp_ready, ex_resp_ready,
    output if_req_ready, ex_req_ready, mem_req_valid, mem_req_data,
    output mem_resp_ready, if_resp_valid, if_resp_data, ex_resp_valid, ex_resp_data
  );

  modport slave (
    output if_req_valid, if_req_data, ex_req_valid, ex_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output if_resp_ready, ex_resp_ready,
    input  if_req_ready, ex_req_ready, mem_req_valid, mem_req_data,
    input  mem_resp_ready, if_resp_valid, if_resp_data, ex_resp_valid, ex_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/execute) round-robin memory arbiter with in-order response
// routing through an owner FIFO; flush marks fetch entries so their data is dropped.
module mem_arbiter #(
  parameter int REQ_W   = 72,
  parameter int RESP_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mem_arbiter_if.master bus,
  output logic          busy
);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);

  typedef enum logic {SRC_IF = 1'b0, SRC_EX = 1'b1} src_e;

  logic [MAX_OUT-1:0] owner_q, owner_d, kill_q, kill_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  src_e               rr_q, rr_d, lock_src_q, lock_src_d;
  logic               lock_q, lock_d, busy_q;

  logic full_s, empty_s, if_elig_s, ex_elig_s, req_ok_s, push_s, pop_s;
  logic head_drop_s, live_s;
  src_e sel_s, head_owner_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PW'(0);
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Request selection and combinational request path
  always_comb begin
    full_s    = (cnt_q == CNT_MAX);
    if_elig_s = bus.if_req_valid && !full_s;
    ex_elig_s = bus.ex_req_valid && !full_s;
    if (lock_q) begin
      sel_s = lock_src_q;
    end else if (if_elig_s && ex_elig_s) begin
      sel_s = rr_q;
    end else if (ex_elig_s) begin
      sel_s = SRC_EX;
    end else begin
      sel_s = SRC_IF;
    end
    req_ok_s          = rst && !full_s;
    bus.mem_req_valid = req_ok_s && ((sel_s == SRC_EX) ? bus.ex_req_valid : bus.if_req_valid);
    bus.mem_req_data  = (sel_s == SRC_EX) ? bus.ex_req_data : bus.if_req_data;
    bus.if_req_ready  = req_ok_s && (sel_s == SRC_IF) && bus.mem_req_ready;
    bus.ex_req_ready  = req_ok_s && (sel_s == SRC_EX) && bus.mem_req_ready;
    push_s            = bus.mem_req_valid && bus.mem_req_ready;
  end

  // Response routing from the owner FIFO head; a flush kills a fetch head in the same cycle
  always_comb begin
    empty_s           = (cnt_q == CW'(0));
    head_owner_s      = src_e'(owner_q[rd_ptr_q]);
    head_drop_s       = kill_q[rd_ptr_q] || (flush && (head_owner_s == SRC_IF));
    live_s            = rst && !empty_s && !head_drop_s;
    bus.if_resp_valid = live_s && (head_owner_s == SRC_IF) && bus.mem_resp_valid;
    bus.ex_resp_valid = live_s && (head_owner_s == SRC_EX) && bus.mem_resp_valid;
    bus.if_resp_data  = bus.mem_resp_data;
    bus.ex_resp_data  = bus.mem_resp_data;
    if (!rst || empty_s) begin
      bus.mem_resp_ready = 1'b0;
    end else if (head_drop_s) begin
      bus.mem_resp_ready = 1'b1;
    end else if (head_owner_s == SRC_EX) begin
      bus.mem_resp_ready = bus.ex_resp_ready;
    end else begin
      bus.mem_resp_ready = bus.if_resp_ready;
    end
    pop_s = bus.mem_resp_valid && bus.mem_resp_ready;
  end

  // Next-state for FIFO, counter, round-robin pointer and lock
  always_comb begin
    owner_d  = owner_q;
    kill_d   = kill_q | (flush ? ~owner_q : {MAX_OUT{1'b0}});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      owner_d[wr_ptr_q] = sel_s;
      kill_d[wr_ptr_q]  = flush && (sel_s == SRC_IF);
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push_s) begin
      rr_d       = (sel_s == SRC_IF) ? SRC_EX : SRC_IF;
      lock_d     = 1'b0;
      lock_src_d = lock_src_q;
    end else if (bus.mem_req_valid) begin
      rr_d       = rr_q;
      lock_d     = 1'b1;
      lock_src_d = sel_s;
    end else begin
      rr_d       = rr_q;
      lock_d     = 1'b0;
      lock_src_d = lock_src_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= {MAX_OUT{1'b0}};
      kill_q     <= {MAX_OUT{1'b0}};
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
      cnt_q      <= CW'(0);
      rr_q       <= SRC_EX;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_IF;
      busy_q     <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      busy_q     <= (cnt_d != CW'(0));
    end
  end

  assign busy = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, lock, routing, flush and reset.
module tb_mem_arbiter;
  localparam int REQ_W   = 72;
  localparam int RESP_W  = 32;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  mem_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) bus ();

  mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.master),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [REQ_W-1:0] pa1 = 72'h11_0000_0000_0000_00A1;
  logic [REQ_W-1:0] pb1 = 72'h22_0000_0000_0000_00B1;
  logic [REQ_W-1:0] pa2 = 72'h33_0000_0000_0000_00A2;
  logic [REQ_W-1:0] pb2 = 72'h44_0000_0000_0000_00B2;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.if_req_valid = 1'b1;  bus.if_req_data = pa1;
    bus.ex_req_valid = 1'b1;  bus.ex_req_data = pb1;
    bus.mem_req_ready = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0;
    bus.if_resp_ready = 1'b1; bus.ex_resp_ready = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mreq_valid", bus.mem_req_valid, 1'b0);
    chk("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
    chk("rst_ex_resp_valid", bus.ex_resp_valid, 1'b0);

    // round robin: ex first after reset, then if, then stall at MAX_OUT
    nxt(); bus.mem_resp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("g1_valid", bus.mem_req_valid, 1'b1);
    chk("g1_data_ex", bus.mem_req_data, pb1);
    chk("g1_ex_ready", bus.ex_req_ready, 1'b1);
    chk("g1_if_ready", bus.if_req_ready, 1'b0);
    nxt();
    @(negedge clk);
    chk("g2_data_if", bus.mem_req_data, pa1);
    chk("g2_if_ready", bus.if_req_ready, 1'b1);
    chk("g2_busy", busy, 1'b1);
    nxt(); bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_00E1;
    @(negedge clk);
    chk("full_mreq_valid", bus.mem_req_valid, 1'b0);
    chk("full_if_ready", bus.if_req_ready, 1'b0);
    chk("full_ex_ready", bus.ex_req_ready, 1'b0);
    chk("full_ex_resp_valid", bus.ex_resp_valid, 1'b1);
    chk("full_ex_resp_data", bus.ex_resp_data, 32'h0000_00E1);
    chk("full_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); bus.mem_resp_data = 32'h0000_00F1;
    @(negedge clk);
    chk("g3_data_ex", bus.mem_req_data, pb1);
    chk("g3_valid", bus.mem_req_valid, 1'b1);
    chk("g3_if_resp_valid", bus.if_resp_valid, 1'b1);
    chk("g3_if_resp_data", bus.if_resp_data, 32'h0000_00F1);
    nxt(); bus.mem_resp_data = 32'h0000_00E2;
    @(negedge clk);
    chk("g4_data_if", bus.mem_req_data, pa1);
    chk("g4_ex_resp_valid", bus.ex_resp_valid, 1'b1);
    nxt(); bus.if_req_valid = 1'b0; bus.ex_req_valid = 1'b0;
    @(negedge clk);
    chk("d_if_resp_valid", bus.if_resp_valid, 1'b1);
    chk("d_mreq_valid", bus.mem_req_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("empty_mresp_ready", bus.mem_resp_ready, 1'b0);
    chk("empty_busy", busy, 1'b0);
    nxt(); bus.mem_resp_valid = 1'b0; bus.mem_req_ready = 1'b0;

    // lock: if held while memory stalls, ex arrives in cycle 2
    bus.if_req_valid = 1'b1; bus.if_req_data = pa2;
    @(negedge clk);
    chk("lk1_valid", bus.mem_req_valid, 1'b1);
    chk("lk1_data", bus.mem_req_data, pa2);
    nxt(); bus.ex_req_valid = 1'b1; bus.ex_req_data = pb2;
    @(negedge clk);
    chk("lk2_data", bus.mem_req_data, pa2);
    chk("lk2_ex_ready", bus.ex_req_ready, 1'b0);
    nxt();
    @(negedge clk);
    chk("lk3_data", bus.mem_req_data, pa2);
    nxt(); bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("lk4_data", bus.mem_req_data, pa2);
    chk("lk4_if_ready", bus.if_req_ready, 1'b1);
    nxt(); bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk("lk5_data_ex", bus.mem_req_data, pb2);
    chk("lk5_ex_ready", bus.ex_req_ready, 1'b1);
    nxt(); bus.ex_req_valid = 1'b0; bus.mem_req_ready = 1'b0;

    // head-of-line: if head stalled, ex behind it waits; then in-order routing
    bus.if_resp_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0011;
    @(negedge clk);
    chk("hol1_mresp_ready", bus.mem_resp_ready, 1'b0);
    chk("hol1_if_resp_valid", bus.if_resp_valid, 1'b1);
    chk("hol1_ex_resp_valid", bus.ex_resp_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("hol2_mresp_ready", bus.mem_resp_ready, 1'b0);
    chk("hol2_busy", busy, 1'b1);
    nxt(); bus.if_resp_ready = 1'b1;
    @(negedge clk);
    chk("r1_if_data", bus.if_resp_data, 32'h0000_0011);
    chk("r1_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); bus.mem_resp_data = 32'h0000_0022;
    @(negedge clk);
    chk("r2_ex_valid", bus.ex_resp_valid, 1'b1);
    chk("r2_ex_data", bus.ex_resp_data, 32'h0000_0022);
    chk("r2_if_valid", bus.if_resp_valid, 1'b0);
    nxt(); bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("r3_busy", busy, 1'b0);

    // flush with two fetch entries outstanding
    nxt(); bus.mem_req_ready = 1'b1; bus.if_req_valid = 1'b1; bus.if_req_data = pa1;
    nxt(); nxt();
    bus.if_req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_busy", busy, 1'b1);
    nxt(); flush = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0033;
    @(negedge clk);
    chk("fl1_if_valid", bus.if_resp_valid, 1'b0);
    chk("fl1_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); bus.mem_resp_data = 32'h0000_0044;
    @(negedge clk);
    chk("fl2_if_valid", bus.if_resp_valid, 1'b0);
    chk("fl2_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("fl_busy_low", busy, 1'b0);

    // flush in the same cycle as a fetch push
    nxt(); bus.if_req_valid = 1'b1; flush = 1'b1;
    nxt(); bus.if_req_valid = 1'b0; flush = 1'b0; bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("pf_if_valid", bus.if_resp_valid, 1'b0);
    chk("pf_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); bus.mem_resp_valid = 1'b0; bus.if_req_valid = 1'b1;
    // flush coinciding with the fetch response at the head
    nxt(); bus.if_req_valid = 1'b0; bus.mem_resp_valid = 1'b1; bus.if_resp_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fh_if_valid", bus.if_resp_valid, 1'b0);
    chk("fh_mresp_ready", bus.mem_resp_ready, 1'b1);
    nxt(); flush = 1'b0; bus.mem_resp_valid = 1'b0; bus.if_resp_ready = 1'b1;
    @(negedge clk);
    chk("fh_busy", busy, 1'b0);
    // execute entries survive a flush
    nxt(); bus.ex_req_valid = 1'b1; flush = 1'b1;
    nxt(); bus.ex_req_valid = 1'b0; flush = 1'b0; bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("exk_ex_valid", bus.ex_resp_valid, 1'b1);
    nxt(); bus.mem_resp_valid = 1'b0;

    // reset mid-transaction with two outstanding
    bus.if_req_valid = 1'b1; bus.ex_req_valid = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    chk("mr_busy_pre", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_mreq_valid", bus.mem_req_valid, 1'b0);
    nxt(); bus.if_req_valid = 1'b0; bus.ex_req_valid = 1'b0; rst = 1'b1; bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("mr_mresp_ready", bus.mem_resp_ready, 1'b0);
    chk("mr_if_valid", bus.if_resp_valid, 1'b0);
    chk("mr_ex_valid", bus.ex_resp_valid, 1'b0);
    chk("mr_busy_post", busy, 1'b0);
    nxt(); bus.mem_resp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter REQ_W, default 72, giving the memory request payload width (address + write data + byte mask + write flag).
REQ-002 The module SHALL have parameter RESP_W, default 32, giving the memory response payload width.
REQ-003 The module SHALL have parameter MAX_OUT, default 2, giving the maximum number of outstanding memory transactions (at least 1, power of 2).
REQ-004 The module SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 The module SHALL have port: rst  in  1  reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port: flush  in  1  pipeline flush; discards pending fetch responses.
REQ-007 The module SHALL have ports: if_req_valid/if_req_ready/if_req_data  in/out/in  1/1/REQ_W  fetch request channel, port 0.
REQ-008 The module SHALL have ports: ex_req_valid/ex_req_ready/ex_req_data  in/out/in  1/1/REQ_W  execute-stage mem unit request channel, port 1.
REQ-009 The module SHALL have ports: mem_req_valid/mem_req_ready/mem_req_data  out/in/out  1/1/REQ_W  shared memory request channel.
REQ-010 The module SHALL have ports: mem_resp_valid/mem_resp_ready/mem_resp_data  in/out/in  1/1/RESP_W  shared memory response channel; responses arrive in request order.
REQ-011 The module SHALL have ports: if_resp_valid/if_resp_ready/if_resp_data and ex_resp_valid/ex_resp_ready/ex_resp_data  out/in/out  1/1/RESP_W  per-port response channels.
REQ-012 The module SHALL have port: busy  out  1  high while any transaction is outstanding.

Function
REQ-013 A transfer on any channel SHALL occur in a cycle where valid and ready are both high.
REQ-014 A source SHALL be eligible when its req_valid is high and the outstanding count is below MAX_OUT.
REQ-015 When exactly one source is eligible and no lock is held, the module SHALL select it.
REQ-016 When both sources are eligible and no lock is held, the module SHALL select the source named by the round-robin pointer.
REQ-017 After each mem_req transfer the pointer SHALL point to the source not just granted.
REQ-018 The request path SHALL be combinational: mem_req_valid = selected source's valid, mem_req_data = its data, its req_ready = mem_req_ready, and the other source's req_ready = 0.
REQ-019 If mem_req_valid is high and mem_req_ready is low, the module SHALL register a lock so the same source stays selected every cycle until the transfer completes.
REQ-020 When the outstanding count equals MAX_OUT, mem_req_valid and both req_ready outputs SHALL be 0, including in a cycle where a response pops.
REQ-021 The module SHALL keep an owner FIFO of depth MAX_OUT with entries {owner, kill}.
REQ-022 A mem_req transfer SHALL push {source, 0} into the owner FIFO.
REQ-023 A mem_resp transfer SHALL pop the owner FIFO.
REQ-024 A push and a pop in the same cycle SHALL leave the outstanding count unchanged.
REQ-025 Response routing to a live head SHALL be combinational: the owner's resp_valid = mem_resp_valid, its resp_data = mem_resp_data, mem_resp_ready = the owner's resp_ready, and the other port's resp_valid = 0.
REQ-026 When the head has kill=1, mem_resp_ready SHALL be 1 and both resp_valid outputs SHALL be 0, so the response is silently dropped.
REQ-027 When the FIFO is empty, mem_resp_ready SHALL be 0.
REQ-028 When flush is high in cycle t, every fetch-owned entry present at the end of cycle t, including one pushed in cycle t, SHALL have kill set.
REQ-029 When flush is high in cycle t and the head is fetch-owned, if_resp_valid SHALL be 0 in cycle t and the response SHALL be dropped as in REQ-026.
REQ-030 Execute-owned entries SHALL never be killed.
REQ-031 flush SHALL NOT affect request arbitration or the lock.
REQ-032 busy SHALL equal (outstanding count != 0), driven from a register.

Reset
REQ-033 While rst is low, the module SHALL clear the outstanding count, FIFO pointers, kill bits and lock, and SHALL set the round-robin pointer to port 1 (ex).
REQ-034 While rst is low, busy SHALL be 0, and mem_req_valid, if_resp_valid and ex_resp_valid SHALL be 0 regardless of inputs.
REQ-035 Reset asserted mid-transaction SHALL abandon all outstanding entries; responses arriving after release with an empty FIFO SHALL be back-pressured per REQ-027.

Verification
REQ-036 The bench SHALL cover: after reset, both req_valid high with mem_req_ready=1 on consecutive cycles -> grants ex, if, ex, if; count reaches 2 and further grants stall.
REQ-037 The bench SHALL cover: if_req_valid held, mem_req_ready low 3 cycles, ex_req_valid rising in cycle 2 -> mem_req_data stays the if payload until accepted; ex is granted next.
REQ-038 The bench SHALL cover: issue if A then ex B, responses 0x11 then 0x22 -> if_resp receives 0x11 and ex_resp receives 0x22, in order.
REQ-039 The bench SHALL cover: two if requests outstanding, flush for 1 cycle, then responses arrive -> both dropped, if_resp_valid never high, busy falls to 0.
REQ-040 The bench SHALL cover: if head with if_resp_ready=0 while an ex entry waits behind it -> mem_resp_ready=0 and the ex response stays stalled until if_resp_ready rises.
REQ-041 The bench SHALL cover: rst pulsed low with count=2 -> busy=0 immediately; a later mem_resp_valid sees mem_resp_ready=0.
